// File: rtl/press_bcd_counter_pkg.sv
// Shared BCD constants and the single-digit increment used by the press counter.
package press_bcd_counter_pkg;

  localparam int         BCD_W    = 4;
  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  // One BCD digit stepped by one; 9 rolls over to 0 (the caller handles the carry).
  function automatic logic [BCD_W-1:0] bcdIncrement(input logic [BCD_W-1:0] digit);
    return (digit == BCD_MAX) ? BCD_ZERO : digit + 4'd1;
  endfunction

endpackage

// File: rtl/press_bcd_counter_debouncer.sv
// Two-flop synchroniser, stability counter and press-edge detection for one
// raw push-button. Everything downstream sees the level as "pressed" = 1.
module button_debouncer
  import press_bcd_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic pressed_level,
  output logic press_pulse,
  output logic press_event
);

  localparam int               CNT_W        = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic             RAW_RELEASED = BTN_ACTIVE_LOW;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pressPulse;
  logic             w_syncPressed;
  logic             w_differs;
  logic             w_accept;

  assign w_syncPressed = r_sync2 ^ RAW_RELEASED;
  assign w_differs     = (w_syncPressed != r_stable);
  assign w_accept      = w_differs && (r_cnt == CNT_LAST);
  assign press_event   = w_accept && w_syncPressed;
  assign pressed_level = r_stable;
  assign press_pulse   = r_pressPulse;

  // Bring the asynchronous button into the clock domain, idling at the released level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= RAW_RELEASED;
      r_sync2 <= RAW_RELEASED;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after it has differed from the stable one for the full window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else if (!w_differs) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_stable <= w_syncPressed;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Strobe for the cycle following a released-to-pressed flip of the stable level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pressPulse <= 1'b0;
    end else begin
      r_pressPulse <= press_event;
    end
  end

endmodule

// File: rtl/press_bcd_counter.sv
// Button press counter front end: debounced presses drive a DIGITS-wide BCD
// count whose digits feed the 7-segment encoders directly.
module press_bcd_counter
  import press_bcd_counter_pkg::*;
#(
  parameter int DIGITS          = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  btn_raw,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  press_pulse,
  output logic                  overflow
);

  logic                      w_pressedLevel;
  logic                      w_pressEvent;
  logic                      w_countEn;
  logic [DIGITS:0]           w_carry;
  logic [BCD_W*DIGITS-1:0]   w_incremented;
  logic [BCD_W*DIGITS-1:0]   r_digits;
  logic                      r_overflow;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
  ) u_debouncer (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_raw       (btn_raw),
    .pressed_level (w_pressedLevel),
    .press_pulse   (press_pulse),
    .press_event   (w_pressEvent)
  );

  // Only a released-to-pressed transition of the stable level advances the count.
  assign w_countEn  = w_pressEvent && !w_pressedLevel;
  assign w_carry[0] = w_countEn;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [BCD_W-1:0] w_cur;
    assign w_cur                           = r_digits[BCD_W*i +: BCD_W];
    assign w_incremented[BCD_W*i +: BCD_W] = w_carry[i] ? bcdIncrement(w_cur) : w_cur;
    assign w_carry[i+1]                    = w_carry[i] && (w_cur == BCD_MAX);
  end

  // Register the rippled count; clear wins over a coincident press and suppresses overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digits   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_carry[DIGITS] && !clr;
      if (clr) begin
        r_digits <= {DIGITS{BCD_ZERO}};
      end else begin
        r_digits <= w_incremented;
      end
    end
  end

  assign digits   = r_digits;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_press_bcd_counter.sv
// Scoreboard bench for press_bcd_counter: a 2-digit active-low counter, a
// 4-digit active-low counter and a 2-digit active-high counter fed the
// inverted button of the first, all with a 4-cycle debounce window.
module tb_press_bcd_counter;

  localparam int DEB         = 4;
  localparam int PULSE_CYCLE = DEB + 2;

  typedef struct {
    logic [15:0] digits;
    logic        ovf;
  } expEntry_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        btnA;
  logic        btnB;
  logic        btnC;
  logic [7:0]  digA;
  logic [7:0]  digC;
  logic [15:0] digB;
  logic        pA, pB, pC;
  logic        oA, oB, oC;

  int          vecCount;
  int          missCount;
  int          modelA;
  int          modelB;
  expEntry_t   sbQ[$];

  always #5 clk = ~clk;

  assign btnC = ~btnA;

  press_bcd_counter #(.DIGITS(2), .DEBOUNCE_CYCLES(DEB), .BTN_ACTIVE_LOW(1'b1)) dutA (
    .clk(clk), .rst_n(rst_n), .btn_raw(btnA), .clr(clr),
    .digits(digA), .press_pulse(pA), .overflow(oA)
  );

  press_bcd_counter #(.DIGITS(4), .DEBOUNCE_CYCLES(DEB), .BTN_ACTIVE_LOW(1'b1)) dutB (
    .clk(clk), .rst_n(rst_n), .btn_raw(btnB), .clr(clr),
    .digits(digB), .press_pulse(pB), .overflow(oB)
  );

  press_bcd_counter #(.DIGITS(2), .DEBOUNCE_CYCLES(DEB), .BTN_ACTIVE_LOW(1'b0)) dutC (
    .clk(clk), .rst_n(rst_n), .btn_raw(btnC), .clr(clr),
    .digits(digC), .press_pulse(pC), .overflow(oC)
  );

  function automatic logic [7:0] toBcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] toBcd4(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // One debounced press on A (mirrored onto C) or on B; expected result queued at drive time.
  task automatic pressOnce(input bit useB, input int holdCycles, input bit clrAtPulse);
    expEntry_t e;
    expEntry_t got;
    int        old;
    logic      pulse;
    logic      ovf;
    if (useB) begin
      old      = modelB;
      modelB   = (modelB + 1) % 10000;
      e.digits = toBcd4(modelB);
      e.ovf    = (old == 9999);
    end else if (clrAtPulse) begin
      modelA   = 0;
      e.digits = 16'h0000;
      e.ovf    = 1'b0;
    end else begin
      old      = modelA;
      modelA   = (modelA + 1) % 100;
      e.digits = {8'h00, toBcd2(modelA)};
      e.ovf    = (old == 99);
    end
    sbQ.push_back(e);
    if (useB) btnB = 1'b0; else btnA = 1'b0;
    for (int c = 1; c <= holdCycles; c++) begin
      @(negedge clk);
      pulse = useB ? pB : pA;
      ovf   = useB ? oB : oA;
      if (c == PULSE_CYCLE) begin
        got = sbQ.pop_front();
        vecCount++;
        if (pulse !== 1'b1) begin
          missCount++;
          $display("[TB] FAIL press_pulse_on_time: got %b expected 1 (cycle %0d)", pulse, c);
        end
        vecCount++;
        if (ovf !== got.ovf) begin
          missCount++;
          $display("[TB] FAIL overflow_at_press: got %b expected %b", ovf, got.ovf);
        end
        if (useB) begin
          vecCount++;
          if (digB !== got.digits) begin
            missCount++;
            $display("[TB] FAIL digits_B: got %h expected %h", digB, got.digits);
          end
        end else begin
          vecCount++;
          if (digA !== got.digits[7:0]) begin
            missCount++;
            $display("[TB] FAIL digits_A: got %h expected %h", digA, got.digits[7:0]);
          end
          vecCount++;
          if (digC !== got.digits[7:0] || pC !== 1'b1 || oC !== got.ovf) begin
            missCount++;
            $display("[TB] FAIL polarity_C: got %h/%b/%b expected %h/1/%b",
                     digC, pC, oC, got.digits[7:0], got.ovf);
          end
        end
        if (clrAtPulse) clr = 1'b0;
      end else begin
        vecCount++;
        if (pulse !== 1'b0 || ovf !== 1'b0) begin
          missCount++;
          $display("[TB] FAIL no_pulse_while_held: got %b/%b expected 0/0 (cycle %0d)", pulse, ovf, c);
        end
        if (clrAtPulse && c == PULSE_CYCLE - 1) clr = 1'b1;
      end
    end
    if (useB) btnB = 1'b1; else btnA = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      pulse = useB ? pB : (pA | pC);
      ovf   = useB ? oB : (oA | oC);
      vecCount++;
      if (pulse !== 1'b0 || ovf !== 1'b0) begin
        missCount++;
        $display("[TB] FAIL release_no_pulse: got %b/%b expected 0/0", pulse, ovf);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vecCount++;
    if (digA !== 8'h00 || digB !== 16'h0000 || digC !== 8'h00) begin
      missCount++;
      $display("[TB] FAIL reset_digits: got %h %h %h expected 00 0000 00", digA, digB, digC);
    end
    vecCount++;
    if ({pA, pB, pC, oA, oB, oC} !== 6'b0) begin
      missCount++;
      $display("[TB] FAIL reset_strobes: got %b expected 000000", {pA, pB, pC, oA, oB, oC});
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    vecCount++;
    if (digA !== 8'h00 || pA !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL after_reset: got %h/%b expected 00/0", digA, pA);
    end
  endtask

  task automatic test_bounce;
    for (int r = 0; r < 5; r++) begin
      btnA = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        vecCount++;
        if (pA !== 1'b0 || pC !== 1'b0) begin
          missCount++;
          $display("[TB] FAIL bounce_pressed: got %b/%b expected 0/0", pA, pC);
        end
      end
      btnA = 1'b1;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        vecCount++;
        if (pA !== 1'b0 || pC !== 1'b0) begin
          missCount++;
          $display("[TB] FAIL bounce_released: got %b/%b expected 0/0", pA, pC);
        end
      end
    end
    repeat (8) @(negedge clk);
    vecCount++;
    if (digA !== 8'h00 || digC !== 8'h00) begin
      missCount++;
      $display("[TB] FAIL bounce_digits: got %h/%h expected 00/00", digA, digC);
    end
  endtask

  task automatic test_clean_press;
    pressOnce(1'b0, 20, 1'b0);
    vecCount++;
    if (digA !== 8'h01) begin
      missCount++;
      $display("[TB] FAIL clean_press_digits: got %h expected 01", digA);
    end
  endtask

  task automatic test_carry;
    while (modelA != 9) pressOnce(1'b0, PULSE_CYCLE, 1'b0);
    vecCount++;
    if (digA !== 8'h09) begin
      missCount++;
      $display("[TB] FAIL carry_09: got %h expected 09", digA);
    end
    pressOnce(1'b0, PULSE_CYCLE, 1'b0);
    vecCount++;
    if (digA !== 8'h10) begin
      missCount++;
      $display("[TB] FAIL carry_10: got %h expected 10", digA);
    end
    while (modelA != 99) pressOnce(1'b0, PULSE_CYCLE, 1'b0);
    pressOnce(1'b0, PULSE_CYCLE, 1'b0);
    vecCount++;
    if (digA !== 8'h00) begin
      missCount++;
      $display("[TB] FAIL wrap_00: got %h expected 00", digA);
    end
  endtask

  task automatic test_clear_race;
    while (modelA != 37) pressOnce(1'b0, PULSE_CYCLE, 1'b0);
    vecCount++;
    if (digA !== 8'h37) begin
      missCount++;
      $display("[TB] FAIL before_clear: got %h expected 37", digA);
    end
    pressOnce(1'b0, PULSE_CYCLE + 2, 1'b1);
    vecCount++;
    if (digA !== 8'h00 || digC !== 8'h00) begin
      missCount++;
      $display("[TB] FAIL after_clear: got %h/%h expected 00/00", digA, digC);
    end
  endtask

  task automatic test_carry4;
    while (modelB != 99) pressOnce(1'b1, PULSE_CYCLE, 1'b0);
    vecCount++;
    if (digB !== 16'h0099) begin
      missCount++;
      $display("[TB] FAIL carry4_0099: got %h expected 0099", digB);
    end
    pressOnce(1'b1, PULSE_CYCLE, 1'b0);
  endtask

  task automatic test_reset_abort;
    for (int n = 0; n < 5; n++) pressOnce(1'b0, PULSE_CYCLE, 1'b0);
    vecCount++;
    if (digA !== toBcd2(modelA)) begin
      missCount++;
      $display("[TB] FAIL before_abort: got %h expected %h", digA, toBcd2(modelA));
    end
    btnA = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    btnA  = 1'b1;
    modelA = 0;
    modelB = 0;
    @(negedge clk);
    vecCount++;
    if (digA !== 8'h00 || digB !== 16'h0000 || digC !== 8'h00 || {pA, pC, oA, oC} !== 4'b0) begin
      missCount++;
      $display("[TB] FAIL abort_reset: got %h %h %h %b expected 00 0000 00 0000",
               digA, digB, digC, {pA, pC, oA, oC});
    end
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      vecCount++;
      if (pA !== 1'b0 || pC !== 1'b0 || digA !== 8'h00) begin
        missCount++;
        $display("[TB] FAIL abort_no_pulse: got %b/%b/%h expected 0/0/00", pA, pC, digA);
      end
    end
  endtask

  initial begin
    vecCount  = 0;
    missCount = 0;
    modelA    = 0;
    modelB    = 0;
    rst_n     = 1'b0;
    clr       = 1'b0;
    btnA      = 1'b1;
    btnB      = 1'b1;
    test_reset();
    test_bounce();
    test_clean_press();
    test_carry();
    test_clear_race();
    test_carry4();
    test_reset_abort();
    vecCount++;
    if (sbQ.size() != 0) begin
      missCount++;
      $display("[TB] FAIL scoreboard_drained: got %0d entries expected 0", sbQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
